// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator DDS oscillator with a quarter-wave sine LUT plus square/saw/triangle.
// Define DDS_AMP_SCALE_EN to add the amp input and a fourth, amplitude-scaling pipeline stage.
module dds_wave_gen #(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 6,
  parameter int OUT_W   = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               en,
  input  logic               tw_load,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [1:0]         wave_sel,
  input  logic               sync,
`ifdef DDS_AMP_SCALE_EN
  input  logic [7:0]         amp,
`endif
  output logic [OUT_W-1:0]   data_out,
  output logic               data_valid,
  output logic               cycle_start
);

  localparam int ENTRIES = 1 << LUT_AW;
  localparam int MAG_W   = OUT_W - 1;
  // Phase bits carried down the pipe: enough for the LUT address and for saw/triangle.
  localparam int S1_W    = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;

  localparam logic [OUT_W-1:0] POS_FS  = {1'b0, {MAG_W{1'b1}}};
  localparam logic [OUT_W-1:0] NEG_FS  = {1'b1, {(MAG_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] MID_BIT = {1'b1, {MAG_W{1'b0}}};

  localparam logic [1:0] SEL_SINE   = 2'b00;
  localparam logic [1:0] SEL_SQUARE = 2'b01;
  localparam logic [1:0] SEL_SAW    = 2'b10;
  localparam logic [1:0] SEL_TRI    = 2'b11;

  // pi/2 in unsigned Q28 fixed point.
  localparam longint HALF_PI_FX = 64'sd421657428;

  // Elaboration-time sine: Taylor series in Q28, then round(M * sin(pi/2*(k+0.5)/ENTRIES)).
  function automatic int sine_entry(input int k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (HALF_PI_FX * longint'(2 * k + 1)) / longint'(2 * ENTRIES);
    x2   = (x * x) >>> 28;
    term = x;
    acc  = x;
    for (int n = 1; n < 10; n++) begin
      term = -(((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    return int'((longint'(POS_FS) * acc + (longint'(1) <<< 27)) >>> 28);
  endfunction

  logic [MAG_W-1:0] sine_lut [ENTRIES];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_lut
      localparam int ENTRY = sine_entry(gi);
      assign sine_lut[gi] = MAG_W'(ENTRY);
    end
  endgenerate

  // ---------------- phase accumulator ----------------
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] tw_q;
  logic [PHASE_W-1:0] phase_sum;
  logic               carry;
  logic               armed_q, armed_d;
  logic               start_now;
  logic [S1_W-1:0]    samp_top;

  // armed_q == 0 means the next emitted sample opens a new period.
  always_comb begin
    {carry, phase_sum} = {1'b0, phase_q} + {1'b0, tw_q};
    phase_d   = phase_q;
    armed_d   = armed_q;
    start_now = ~armed_q;
    samp_top  = phase_q[PHASE_W-1 -: S1_W];
    if (sync) begin
      start_now = 1'b1;
      samp_top  = '0;
      if (en) begin
        // Sample phase 0 now and continue from 0 + TW so phase 0 is not repeated.
        phase_d = tw_q;
        armed_d = 1'b1;
      end else begin
        phase_d = '0;
        armed_d = 1'b0;
      end
    end else if (en) begin
      phase_d = phase_sum;
      armed_d = ~carry;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      phase_q <= '0;
      tw_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      armed_q <= armed_d;
      if (tw_load) begin
        tw_q <= tuning_word;
      end
    end
  end

  // ---------------- S1: capture sample phase ----------------
  logic            s1_valid_q;
  logic            s1_start_q;
  logic [1:0]      s1_sel_q;
  logic [S1_W-1:0] s1_ph_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid_q <= 1'b0;
      s1_start_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_ph_q    <= '0;
    end else begin
      s1_valid_q <= en;
      s1_start_q <= en & start_now;
      if (en) begin
        s1_sel_q <= wave_sel;
        s1_ph_q  <= samp_top;
      end
    end
  end

  // ---------------- S2: quarter-wave LUT read ----------------
  logic [LUT_AW-1:0] lut_idx;
  logic [MAG_W-1:0]  s2_mag_q;
  logic [OUT_W:0]    s2_top_q;
  logic [1:0]        s2_sel_q;
  logic              s2_valid_q;
  logic              s2_start_q;

  // Odd quadrants run the table backwards.
  assign lut_idx = s1_ph_q[S1_W-2] ? ~s1_ph_q[S1_W-3 -: LUT_AW] : s1_ph_q[S1_W-3 -: LUT_AW];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s2_mag_q   <= '0;
      s2_top_q   <= '0;
      s2_sel_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_start_q <= 1'b0;
    end else begin
      s2_mag_q   <= sine_lut[lut_idx];
      s2_top_q   <= s1_ph_q[S1_W-1 -: OUT_W+1];
      s2_sel_q   <= s1_sel_q;
      s2_valid_q <= s1_valid_q;
      s2_start_q <= s1_start_q;
    end
  end

  // ---------------- S3: sign / waveform select ----------------
  logic [OUT_W-1:0] mag_ext;
  logic [OUT_W-1:0] ramp_fold;
  logic [OUT_W-1:0] wave;

  always_comb begin
    mag_ext   = {1'b0, s2_mag_q};
    ramp_fold = s2_top_q[OUT_W] ? ~s2_top_q[OUT_W-1:0] : s2_top_q[OUT_W-1:0];
    wave      = '0;
    case (s2_sel_q)
      SEL_SINE:   wave = s2_top_q[OUT_W] ? -mag_ext : mag_ext;
      SEL_SQUARE: wave = s2_top_q[OUT_W] ? NEG_FS : POS_FS;
      SEL_SAW:    wave = s2_top_q[OUT_W:1];
      SEL_TRI:    wave = ramp_fold ^ MID_BIT;
      default:    wave = '0;
    endcase
  end

  logic [OUT_W-1:0] data_out_q;
  logic             data_valid_q;
  logic             cycle_start_q;

`ifdef DDS_AMP_SCALE_EN
  logic [OUT_W-1:0]        s3_wave_q;
  logic                    s3_valid_q;
  logic                    s3_start_q;
  logic signed [OUT_W+8:0] scaled_full;
  logic                    scaled_fits;
  logic [OUT_W-1:0]        scaled_sat;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s3_wave_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_start_q <= 1'b0;
    end else begin
      s3_valid_q <= s2_valid_q;
      s3_start_q <= s2_valid_q & s2_start_q;
      if (s2_valid_q) begin
        s3_wave_q <= wave;
      end
    end
  end

  // amp is Q1.7 unsigned: 128 is unity gain.
  assign scaled_full = ($signed(s3_wave_q) * $signed({1'b0, amp})) >>> 7;
  assign scaled_fits = (&scaled_full[OUT_W+8:OUT_W-1]) | ~(|scaled_full[OUT_W+8:OUT_W-1]);
  assign scaled_sat  = scaled_fits ? scaled_full[OUT_W-1:0]
                                   : (scaled_full[OUT_W+8] ? MID_BIT : POS_FS);

  // ---------------- S4: amplitude scaling ----------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      data_valid_q  <= s3_valid_q;
      cycle_start_q <= s3_valid_q & s3_start_q;
      if (s3_valid_q) begin
        data_out_q <= scaled_sat;
      end
    end
  end
`else
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      data_valid_q  <= s2_valid_q;
      cycle_start_q <= s2_valid_q & s2_start_q;
      if (s2_valid_q) begin
        data_out_q <= wave;
      end
    end
  end
`endif

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a behavioural phase/wave model pushes expected samples,
// a negedge monitor pops and checks value, cycle_start and latency of every valid output.
`timescale 1ns/1ps
module tb_dds_wave_gen;
`ifdef DDS_AMP_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tw_load = 1'b0;
  logic        sync = 1'b0;
  logic [23:0] tuning_word = '0;
  logic [1:0]  wave_sel = '0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        cycle_start;
`ifdef DDS_AMP_SCALE_EN
  logic [7:0]  amp = 8'd128;
`endif

  dds_wave_gen dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .en(en),
    .tw_load(tw_load),
    .tuning_word(tuning_word),
    .wave_sel(wave_sel),
    .sync(sync),
`ifdef DDS_AMP_SCALE_EN
    .amp(amp),
`endif
    .data_out(data_out),
    .data_valid(data_valid),
    .cycle_start(cycle_start)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic       st;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mx;
  logic [7:0] cap_d[$];
  logic       cap_s[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] last_out = '0;
  logic [23:0] m_phase;
  logic [23:0] m_tw;
  bit          m_pend;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_wave(input logic [23:0] ph, input logic [1:0] sel);
    int idx;
    int mag;
    real ang;
    logic [7:0] t;
    case (sel)
      2'b00: begin
        idx = int'(ph[21:16]);
        if (ph[22]) idx = 63 - idx;
        ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / 64.0;
        mag = int'($floor(127.0 * $sin(ang) + 0.5));
        return ph[23] ? 8'(-mag) : 8'(mag);
      end
      2'b01: return ph[23] ? 8'h81 : 8'h7F;
      2'b10: return ph[23:16];
      default: begin
        t = ph[22:15];
        if (ph[23]) t = 8'd255 - t;
        return t - 8'd128;
      end
    endcase
  endfunction

  // One clock of stimulus; the model predicts the sample and the next phase state.
  task automatic step(input bit e, input bit s, input bit ld, input logic [23:0] tw,
                      input logic [1:0] sel);
    logic [24:0] nxt;
    logic [23:0] ph;
    exp_t x;
    en = e; sync = s; tw_load = ld; tuning_word = tw; wave_sel = sel;
    if (e) begin
      ph = s ? 24'd0 : m_phase;
      x.data = model_wave(ph, sel);
      x.st = s | m_pend;
      x.cyc = cyc + LAT;
      sb.push_back(x);
    end
    if (s) begin
      m_phase = e ? m_tw : 24'd0;
      m_pend = !e;
    end else if (e) begin
      nxt = {1'b0, m_phase} + {1'b0, m_tw};
      m_phase = nxt[23:0];
      m_pend = nxt[24];
    end
    if (ld) m_tw = tw;
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (!Rst_n) begin
      last_out = '0;
    end else if (data_valid) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_valid: got data_valid=1 exp no pending sample (cyc %0d)", cyc);
      end
      if (sb.size() != 0) begin
        mx = sb.pop_front();
        tests++;
        assert (data_out === mx.data) else begin
          fails++;
          $error("FAIL sample_data: got %0d exp %0d (cyc %0d)", $signed(data_out), $signed(mx.data), cyc);
        end
        tests++;
        assert (cycle_start === mx.st) else begin
          fails++;
          $error("FAIL cycle_start: got %0b exp %0b (cyc %0d)", cycle_start, mx.st, cyc);
        end
        tests++;
        assert (cyc === mx.cyc) else begin
          fails++;
          $error("FAIL latency: got valid at cyc %0d exp cyc %0d", cyc, mx.cyc);
        end
      end
      cap_d.push_back(data_out);
      cap_s.push_back(cycle_start);
      last_out = data_out;
    end else begin
      tests++;
      assert (data_out === last_out && cycle_start === 1'b0) else begin
        fails++;
        $error("FAIL idle_hold: got data_out=%0d cycle_start=%0b exp data_out=%0d cycle_start=0",
               $signed(data_out), cycle_start, $signed(last_out));
      end
    end
  end

  int spot_n[7] = '{0, 63, 64, 127, 128, 191, 192};
  int spot_v[7] = '{2, 127, 127, 2, -2, -127, -127};

  initial begin
    m_phase = '0;
    m_tw = '0;
    m_pend = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    tests++;
    assert (data_out === 8'h00 && data_valid === 1'b0 && cycle_start === 1'b0) else begin
      fails++;
      $error("FAIL reset_state: got data_out=%0h data_valid=%0b cycle_start=%0b exp 0/0/0",
             data_out, data_valid, cycle_start);
    end
    Rst_n = 1'b1;

    // Sine, TW = 2**16, one full period plus the next wrap.
    step(1'b0, 1'b0, 1'b1, 24'h010000, 2'b00);
    for (int n = 0; n < 257; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b00);
    // Square then saw, continuous.
    for (int n = 0; n < 256; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b01);
    for (int n = 0; n < 256; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b10);
    // Triangle with en toggling.
    for (int n = 0; n < 512; n++) step((n % 2) == 0, 1'b0, 1'b0, 24'h0, 2'b11);
    // Sine with a tuning-word change and a hard sync.
    for (int n = 0; n < 160; n++)
      step(1'b1, n == 100, n == 50, (n == 50) ? 24'h020000 : 24'h0, 2'b00);
    // Sync without en, then resume.
    step(1'b0, 1'b1, 1'b0, 24'h0, 2'b00);
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b00);
    // Aliasing tuning word on the saw.
    step(1'b0, 1'b0, 1'b1, 24'hC00000, 2'b10);
    for (int n = 0; n < 12; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b10);
    // Mid-stream asynchronous reset.
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b1, 24'h010000, 2'b00);
    #2;
    Rst_n = 1'b0;
    #1;
    tests++;
    assert (data_out === 8'h00 && data_valid === 1'b0 && cycle_start === 1'b0) else begin
      fails++;
      $error("FAIL async_reset: got data_out=%0h data_valid=%0b cycle_start=%0b exp 0/0/0",
             data_out, data_valid, cycle_start);
    end
    sb.delete();
    m_phase = '0;
    m_tw = '0;
    m_pend = 1'b1;
    en = 1'b0; tw_load = 1'b0; sync = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    // TW is 0 after reset: constant phase 0, samples keep coming.
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b00);
    step(1'b1, 1'b0, 1'b1, 24'h010000, 2'b00);
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 1'b0, 24'h0, 2'b00);
    // Drain the pipe (bounded).
    for (int n = 0; n < LAT + 2; n++) step(1'b0, 1'b0, 1'b0, 24'h0, 2'b00);
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: got %0d samples still pending exp 0", sb.size());
    end

    // Fixed reference points of the first sine period.
    for (int i = 0; i < 7; i++) begin
      tests++;
      assert (cap_d.size() > spot_n[i] && int'($signed(cap_d[spot_n[i]])) == spot_v[i]) else begin
        fails++;
        $error("FAIL sine_point_%0d: got %0d exp %0d", spot_n[i],
               (cap_d.size() > spot_n[i]) ? int'($signed(cap_d[spot_n[i]])) : -999, spot_v[i]);
      end
    end
    tests++;
    assert (cap_s.size() > 256 && cap_s[0] === 1'b1 && cap_s[1] === 1'b0 && cap_s[256] === 1'b1) else begin
      fails++;
      $error("FAIL period_start: got start flags n0/n1/n256 = %0b/%0b/%0b exp 1/0/1",
             (cap_s.size() > 0) ? cap_s[0] : 1'bx, (cap_s.size() > 1) ? cap_s[1] : 1'bx,
             (cap_s.size() > 256) ? cap_s[256] : 1'bx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
